// File: rtl/id_issue_stage_pkg.sv
// Shared decode definitions for the ID issue stage and the EX-stage ALU.
package id_issue_stage_pkg;

    localparam int REG_ADDR_W = 5;

    // Instruction field bit positions (LSB of each field)
    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] FN_SRL    = 6'b000010;
    localparam logic [5:0] FN_ADD    = 6'b001011;
    localparam logic [5:0] FN_SUB    = 6'b001101;
    localparam logic [5:0] FN_OR     = 6'b100101;

    typedef struct packed {
        logic [5:0]            opcode;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [4:0]            shamt;
        logic [5:0]            funct;
    } instr_t;

    // Split a raw instruction word into its fields
    function automatic instr_t decode(input logic [31:0] w);
        instr_t d;
        d.opcode = w[OPC_LSB   +: 6];
        d.rs     = w[RS_LSB    +: REG_ADDR_W];
        d.rt     = w[RT_LSB    +: REG_ADDR_W];
        d.rd     = w[RD_LSB    +: REG_ADDR_W];
        d.shamt  = w[SHAMT_LSB +: 5];
        d.funct  = w[FUNCT_LSB +: 6];
        return d;
    endfunction

    function automatic logic is_legal(input instr_t i);
        return (i.opcode == OPC_RTYPE) &&
               ((i.funct == FN_SRL) || (i.funct == FN_ADD) ||
                (i.funct == FN_SUB) || (i.funct == FN_OR));
    endfunction

endpackage

// File: rtl/id_issue_stage_reg_file.sv
// 32-entry register file: two combinational reads, one write, R0 hardwired
// to zero, and same-cycle writeback bypass onto both read ports.
module reg_file_2r1w
    import id_issue_stage_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] REG_INIT = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              wr_live;

    // A write to R0 is never live, so it neither stores nor bypasses
    assign wr_live = wb_en && (wb_addr != '0);

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] a);
        if (a == '0)
            return '0;
        else if (wr_live && (wb_addr == a))
            return wb_data;
        else
            return mem[a];
    endfunction

    // Combinational read ports with writeback bypass
    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

    // Storage: reset init (R0 entry is never read), then writeback writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                mem[i] <= (i == 0) ? '0 : REG_INIT;
        end else if (wr_live) begin
            mem[wb_addr] <= wb_data;
        end
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode / operand-issue stage feeding the ALU through the ID/EX register.
// Stalls one cycle when the instruction in ID/EX produces a source the
// incoming instruction needs; the result then arrives on the bypass path.
module id_issue_stage
    import id_issue_stage_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] REG_INIT = '0,
    parameter int                CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Instr_Valid,
    input  logic [31:0]           Instr,
    output logic                  Instr_Ready,
    input  logic                  WB_En,
    input  logic [REG_ADDR_W-1:0] WB_Addr,
    input  logic [DATA_W-1:0]     WB_Data,
    output logic                  EX_Valid,
    output logic [DATA_W-1:0]     Src_1,
    output logic [DATA_W-1:0]     Src_2,
    output logic [4:0]            Shamt,
    output logic [5:0]            Funct,
    output logic [REG_ADDR_W-1:0] Dest,
    output logic                  Illegal,
    output logic [CNT_W-1:0]      Stall_Count
);

    instr_t                ins;
    logic                  legal;
    logic                  is_srl;
    logic                  uses_dest;
    logic                  hazard;
    logic                  transfer;
    logic [REG_ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0]     data_a;
    logic [DATA_W-1:0]     data_b;

    assign ins    = decode(Instr);
    assign legal  = is_legal(ins);
    assign is_srl = (ins.funct == FN_SRL);

    // SRL shifts R[rt], so port A reads rt instead of rs
    assign addr_a = is_srl ? ins.rt : ins.rs;

    reg_file_2r1w #(
        .DATA_W   (DATA_W),
        .REG_INIT (REG_INIT)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (addr_a),
        .rd_addr_b (ins.rt),
        .rd_data_a (data_a),
        .rd_data_b (data_b),
        .wb_en     (WB_En),
        .wb_addr   (WB_Addr),
        .wb_data   (WB_Data)
    );

    // RAW hazard against the instruction currently in ID/EX; only sources
    // the instruction actually reads count (SRL ignores rs)
    always_comb begin
        uses_dest = (Dest == ins.rt) || (!is_srl && (Dest == ins.rs));
        hazard    = Instr_Valid && legal && EX_Valid && (Dest != '0) && uses_dest;
    end

    assign Instr_Ready = !hazard;
    assign transfer    = Instr_Valid && Instr_Ready;

    // ID/EX register: latch operands on legal transfer, zero on illegal,
    // hold data (with valid/illegal cleared) when nothing transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            EX_Valid <= 1'b0;
            Illegal  <= 1'b0;
            Src_1    <= '0;
            Src_2    <= '0;
            Shamt    <= '0;
            Funct    <= '0;
            Dest     <= '0;
        end else begin
            EX_Valid <= 1'b0;
            Illegal  <= 1'b0;
            if (transfer) begin
                if (legal) begin
                    EX_Valid <= 1'b1;
                    Src_1    <= data_a;
                    Src_2    <= is_srl ? '0 : data_b;
                    Shamt    <= ins.shamt;
                    Funct    <= ins.funct;
                    Dest     <= ins.rd;
                end else begin
                    Illegal  <= 1'b1;
                    Src_1    <= '0;
                    Src_2    <= '0;
                    Shamt    <= '0;
                    Funct    <= '0;
                    Dest     <= '0;
                end
            end
        end
    end

    // Saturating count of cycles spent stalled on a hazard
    always_ff @(posedge clk) begin
        if (rst)
            Stall_Count <= '0;
        else if (hazard && (Stall_Count != '1))
            Stall_Count <= Stall_Count + 1'b1;
    end

endmodule
